rx_pack64: RTL and testbench



---
 rtl/rx_pkg.sv | 25 ++
 rtl/rx_pack64_if.sv | 33 +++
 rtl/sio_fifo_fwft.sv | 101 ++++++++++
 rtl/rx_pack64.sv | 112 +++++++++++
 tb/tb_rx_pack64.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_pkg.sv
// Shared types and constants for the receive-side 32->64 packer and the DMA framer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rx_pkg;

    // Filler for the low half when a lone word is pushed out without a partner.
    localparam logic [31:0] PAD_WORD = 32'h0;

    // Width of the saturating overflow counter.
    localparam int OVF_W = 16;

    // 64-bit packed word: the first word received is in the upper half.
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } pack_word_t;

    function automatic pack_word_t make_word(input logic [31:0] hi, input logic [31:0] lo);
        pack_word_t w;
        w.hi = hi;
        w.lo = lo;
        return w;
    endfunction

endpackage

// File: rtl/rx_pack64_if.sv
// Bus bundle between the receiver stream, the packer and the host DMA consumer.
// Latency: n/a (wires only).
// Backpressure: oready from the consumer; the input side has none (ivalid is never stalled).
// Ports: ivalid/idata/flush/clear_overflow/oready toward the packer,
//        ovalid/odata/level/overflow_count from the packer.
interface rx_pack64_if #(
    parameter int LVL_W = 5
);
    import rx_pkg::*;

    logic              ivalid;
    logic [31:0]       idata;
    logic              flush;
    logic              clear_overflow;
    logic              ovalid;
    pack_word_t        odata;
    logic              oready;
    logic [LVL_W-1:0]  level;
    logic [OVF_W-1:0]  overflow_count;

    // Packer side.
    modport slave (
        input  ivalid, idata, flush, clear_overflow, oready,
        output ovalid, odata, level, overflow_count
    );

    // Stimulus / consumer side.
    modport master (
        output ivalid, idata, flush, clear_overflow, oready,
        input  ovalid, odata, level, overflow_count
    );

endinterface

// File: rtl/sio_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with a registered head (dout/valid are flops).
// Latency: a push into an empty FIFO is visible on dout/!empty the next cycle.
// Backpressure: dout holds while !empty && !pop; push while full is ignored unless a pop
//               happens in the same cycle, in which case it is accepted.
// Ports: clk/rst (sync, active-high), push_i/din_i, pop_i, dout_o, full_o, empty_o, level_o.
module sio_fifo_fwft #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Entries behind the head live in mem_q; level_q counts head + mem entries.
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             head_vld_q, head_vld_d;

    logic pop_ok, push_ok, mem_empty, mem_wr;

    assign pop_ok    = pop_i & head_vld_q;
    assign full_o    = (level_q == LW'(DEPTH));
    // A pop frees a slot in the same cycle, so a push while full is still taken.
    assign push_ok   = push_i & (~full_o | pop_ok);
    // With a valid head, anything beyond one entry sits in memory.
    assign mem_empty = (level_q <= LW'(1));

    always_comb begin
        head_d     = head_q;
        head_vld_d = head_vld_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_wr     = 1'b0;
        level_d    = level_q;

        if (!head_vld_q || (pop_ok && mem_empty)) begin
            // Head is (or is about to be) free and nothing queued behind it:
            // the incoming word bypasses memory straight into the head.
            head_vld_d = push_ok;
            if (push_ok) begin
                head_d = din_i;
            end
        end else begin
            if (pop_ok) begin
                head_d   = mem_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            mem_wr = push_ok;
        end

        if (mem_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o  = head_q;
    assign empty_o = ~head_vld_q;
    assign level_o = level_q;

endmodule

// File: rtl/rx_pack64.sv
// Packs consecutive 32-bit receiver words into 64-bit words and queues them toward host DMA.
// Latency: the push happens in the cycle the second word (or flush/timeout) arrives; ovalid one cycle later.
// Backpressure: oready drains the FWFT queue; the input is never stalled, so a full queue drops and counts.
// Ports: clock/reset (sync, active-high); bus.slave carries ivalid/idata/flush/clear_overflow/oready in
//        and ovalid/odata/level/overflow_count out.
module rx_pack64
    import rx_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int FLUSH_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    rx_pack64_if.slave  bus
);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    // Idle count reached on the last idle cycle before the timeout push.
    localparam logic [15:0] IDLE_LAST = 16'(FLUSH_CYCLES - 1);

    logic              pending_q, pending_d;
    logic [31:0]       half_q, half_d;
    logic [15:0]       idle_q, idle_d;
    logic [OVF_W-1:0]  ovf_q, ovf_d;

    logic              push_vld;
    pack_word_t        push_dat;
    logic              fifo_full, fifo_empty, fifo_pop, dropped;
    logic [63:0]       fifo_dout;
    logic [LVL_W-1:0]  fifo_level;

    // Pairing, timeout and flush. The branches are disjoint, so at most one push per cycle.
    always_comb begin
        pending_d = pending_q;
        half_d    = half_q;
        idle_d    = idle_q;
        push_vld  = 1'b0;
        push_dat  = '0;

        if (bus.ivalid) begin
            idle_d = '0;
            if (pending_q) begin
                push_vld  = 1'b1;
                push_dat  = make_word(half_q, bus.idata);
                pending_d = 1'b0;
            end else if (bus.flush) begin
                // Lone word with flush: send it straight out padded, never hold it.
                push_vld  = 1'b1;
                push_dat  = make_word(bus.idata, PAD_WORD);
            end else begin
                half_d    = bus.idata;
                pending_d = 1'b1;
            end
        end else if (pending_q) begin
            if (bus.flush || (idle_q == IDLE_LAST)) begin
                push_vld  = 1'b1;
                push_dat  = make_word(half_q, PAD_WORD);
                pending_d = 1'b0;
                idle_d    = '0;
            end else begin
                idle_d    = idle_q + 16'd1;
            end
        end
    end

    assign fifo_pop = bus.oready & ~fifo_empty;
    assign dropped  = push_vld & fifo_full & ~fifo_pop;

    // A clear that coincides with a drop still records that drop.
    always_comb begin
        ovf_d = ovf_q;
        if (bus.clear_overflow) begin
            ovf_d = dropped ? OVF_W'(1) : '0;
        end else if (dropped && (ovf_q != {OVF_W{1'b1}})) begin
            ovf_d = ovf_q + OVF_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q <= 1'b0;
            half_q    <= '0;
            idle_q    <= '0;
            ovf_q     <= '0;
        end else begin
            pending_q <= pending_d;
            half_q    <= half_d;
            idle_q    <= idle_d;
            ovf_q     <= ovf_d;
        end
    end

    sio_fifo_fwft #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .push_i  (push_vld),
        .din_i   (push_dat),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign bus.ovalid         = ~fifo_empty;
    assign bus.odata          = fifo_dout;
    assign bus.level          = fifo_level;
    assign bus.overflow_count = ovf_q;

endmodule

// File: tb/tb_rx_pack64.sv
// Self-checking bench for rx_pack64: directed scenarios plus a randomized backpressure run
// scored against a queue of expected 64-bit words built from the pairing rules.
module tb_rx_pack64;
    localparam int DEPTH = 16;
    localparam int FLUSH = 64;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clock = 1'b0;
    logic reset = 1'b1;

    rx_pack64_if #(.LVL_W(LW)) bus ();

    rx_pack64 #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #4 clock = ~clock;

    int vectors    = 0;
    int miscompares = 0;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        bus.ivalid = 1'b0;
        bus.idata = '0;
        bus.flush = 1'b0;
        bus.clear_overflow = 1'b0;
    endtask

    task automatic do_reset();
        quiet();
        bus.oready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic send(input logic [31:0] w);
        bus.ivalid = 1'b1;
        bus.idata = w;
        step();
        bus.ivalid = 1'b0;
    endtask

    task automatic test_reset();
        bus.ivalid = 1'b1;
        bus.idata = 32'hDEAD_BEEF;
        bus.oready = 1'b1;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        quiet();
        bus.oready = 1'b0;
        vectors++;
        if (bus.ovalid !== 1'b0) begin miscompares++; $display("FAIL reset_ovalid got %b want 0", bus.ovalid); end
        vectors++;
        if (bus.odata !== 64'h0) begin miscompares++; $display("FAIL reset_odata got %h want 0", bus.odata); end
        vectors++;
        if (bus.level !== LW'(0)) begin miscompares++; $display("FAIL reset_level got %0d want 0", bus.level); end
        vectors++;
        if (bus.overflow_count !== 16'd0) begin miscompares++; $display("FAIL reset_ovf got %0d want 0", bus.overflow_count); end
    endtask

    task automatic test_pairing();
        do_reset();
        send(32'hAAAA0001);
        vectors++;
        if (bus.ovalid !== 1'b0) begin miscompares++; $display("FAIL pair_half_ovalid got %b want 0", bus.ovalid); end
        send(32'hBBBB0002);
        vectors++;
        if (bus.ovalid !== 1'b1) begin miscompares++; $display("FAIL pair_ovalid got %b want 1", bus.ovalid); end
        vectors++;
        if (bus.odata !== 64'hAAAA0001_BBBB0002) begin miscompares++; $display("FAIL pair_odata got %h want AAAA0001BBBB0002", bus.odata); end
        vectors++;
        if (bus.level !== LW'(1)) begin miscompares++; $display("FAIL pair_level got %0d want 1", bus.level); end
    endtask

    task automatic test_timeout();
        logic early;
        do_reset();
        early = 1'b0;
        send(32'h12345600);            // cycle 0
        for (int k = 1; k < FLUSH; k++) begin
            step();                    // cycles 1..63 idle, no push yet
            if (bus.ovalid !== 1'b0) early = 1'b1;
        end
        vectors++;
        if (early !== 1'b0) begin miscompares++; $display("FAIL timeout_early got ovalid before cycle 65 want none"); end
        step();                        // cycle 64 pushes
        vectors++;
        if (bus.ovalid !== 1'b1) begin miscompares++; $display("FAIL timeout_ovalid got %b want 1", bus.ovalid); end
        vectors++;
        if (bus.odata !== 64'h12345600_00000000) begin miscompares++; $display("FAIL timeout_odata got %h want 1234560000000000", bus.odata); end
    endtask

    task automatic test_flush();
        do_reset();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        vectors++;
        if (bus.level !== LW'(0)) begin miscompares++; $display("FAIL flush_idle_level got %0d want 0", bus.level); end

        bus.flush = 1'b1;
        send(32'hCAFE0000);
        bus.flush = 1'b0;
        vectors++;
        if (bus.odata !== 64'hCAFE0000_00000000 || bus.ovalid !== 1'b1) begin
            miscompares++; $display("FAIL flush_direct got %h/%b want CAFE000000000000/1", bus.odata, bus.ovalid);
        end
        bus.oready = 1'b1;
        step();
        bus.oready = 1'b0;

        // pending + flush, no ivalid
        send(32'h11110000);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        vectors++;
        if (bus.odata !== 64'h11110000_00000000 || bus.level !== LW'(1)) begin
            miscompares++; $display("FAIL flush_pending got %h lvl %0d want 1111000000000000 lvl 1", bus.odata, bus.level);
        end
        bus.oready = 1'b1;
        step();
        bus.oready = 1'b0;

        // pending + flush + ivalid: just the normal pair
        send(32'h22220001);
        bus.flush = 1'b1;
        send(32'h22220002);
        bus.flush = 1'b0;
        step();
        vectors++;
        if (bus.odata !== 64'h22220001_22220002 || bus.level !== LW'(1)) begin
            miscompares++; $display("FAIL flush_with_pair got %h lvl %0d want 2222000122220002 lvl 1", bus.odata, bus.level);
        end
    endtask

    task automatic test_overflow();
        logic [63:0] head;
        do_reset();
        for (int i = 0; i < 36; i++) begin
            bus.ivalid = 1'b1;
            bus.idata = 32'hF000_0000 + i;
            step();
        end
        bus.ivalid = 1'b0;
        vectors++;
        if (bus.level !== LW'(16)) begin miscompares++; $display("FAIL ovf_level got %0d want 16", bus.level); end
        vectors++;
        if (bus.overflow_count !== 16'd2) begin miscompares++; $display("FAIL ovf_count got %0d want 2", bus.overflow_count); end

        send(32'hA0A0_0001);
        bus.ivalid = 1'b1;
        bus.idata = 32'hA0A0_0002;
        bus.oready = 1'b1;
        head = bus.odata;
        step();
        bus.ivalid = 1'b0;
        bus.oready = 1'b0;
        vectors++;
        if (head !== 64'hF0000000_F0000001) begin miscompares++; $display("FAIL ovf_head got %h want F0000000F0000001", head); end
        vectors++;
        if (bus.level !== LW'(16) || bus.overflow_count !== 16'd2) begin
            miscompares++; $display("FAIL ovf_pushpop got lvl %0d cnt %0d want 16/2", bus.level, bus.overflow_count);
        end

        bus.clear_overflow = 1'b1;
        step();
        bus.clear_overflow = 1'b0;
        vectors++;
        if (bus.overflow_count !== 16'd0) begin miscompares++; $display("FAIL ovf_clear got %0d want 0", bus.overflow_count); end

        send(32'hB0B0_0001);
        bus.clear_overflow = 1'b1;
        send(32'hB0B0_0002);
        bus.clear_overflow = 1'b0;
        vectors++;
        if (bus.overflow_count !== 16'd1) begin miscompares++; $display("FAIL ovf_clear_coincide got %0d want 1", bus.overflow_count); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_q[$];
        logic [31:0] first;
        logic [63:0] prev_dat;
        logic        prev_stall;
        logic [63:0] want;
        int          sent;
        int          cyc;
        do_reset();
        sent = 0;
        cyc = 0;
        first = '0;
        prev_stall = 1'b0;
        prev_dat = '0;
        while ((sent < 2000 || exp_q.size() > 0) && cyc < 20000) begin
            bus.ivalid = (sent < 2000) && ($urandom_range(0, 1) == 1);
            bus.idata = $urandom;
            bus.oready = ($urandom_range(0, 1) == 1);
            if (bus.ivalid) begin
                if (sent % 2 == 0) first = bus.idata;
                else exp_q.push_back({first, bus.idata});
                sent++;
            end
            if (prev_stall) begin
                vectors++;
                if (bus.ovalid !== 1'b1 || bus.odata !== prev_dat) begin
                    miscompares++; $display("FAIL bp_stable got %h/%b want %h/1", bus.odata, bus.ovalid, prev_dat);
                end
            end
            if (bus.ovalid && bus.oready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++; $display("FAIL bp_extra got %h want no word", bus.odata);
                end else begin
                    want = exp_q.pop_front();
                    if (bus.odata !== want) begin
                        miscompares++; $display("FAIL bp_order got %h want %h", bus.odata, want);
                    end
                end
            end
            prev_stall = bus.ovalid && !bus.oready;
            prev_dat = bus.odata;
            step();
            cyc++;
        end
        quiet();
        bus.oready = 1'b0;
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL bp_drain got %0d left want 0", exp_q.size()); end
        vectors++;
        if (bus.level !== LW'(0) || bus.overflow_count !== 16'd0) begin
            miscompares++; $display("FAIL bp_end got lvl %0d cnt %0d want 0/0", bus.level, bus.overflow_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 11; i++) begin
            bus.ivalid = 1'b1;
            bus.idata = 32'h5000_0000 + i;
            step();
        end
        bus.ivalid = 1'b0;
        vectors++;
        if (bus.level !== LW'(5)) begin miscompares++; $display("FAIL mid_pre_level got %0d want 5", bus.level); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++;
        if (bus.ovalid !== 1'b0 || bus.level !== LW'(0)) begin
            miscompares++; $display("FAIL mid_reset got ovalid %b lvl %0d want 0/0", bus.ovalid, bus.level);
        end
        send(32'h6666_0001);
        vectors++;
        if (bus.level !== LW'(0)) begin miscompares++; $display("FAIL mid_new_half got lvl %0d want 0", bus.level); end
        send(32'h6666_0002);
        vectors++;
        if (bus.odata !== 64'h66660001_66660002 || bus.level !== LW'(1)) begin
            miscompares++; $display("FAIL mid_new_pair got %h lvl %0d want 6666000166660002 lvl 1", bus.odata, bus.level);
        end
    endtask

    initial begin
        quiet();
        bus.oready = 1'b0;
        test_reset();
        test_pairing();
        test_timeout();
        test_flush();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
